twos_to_signmag_serial: RTL and testbench
=========================================

Name: twos_to_signmag_serial

Overview:
Bit-serial converter from a two's-complement word to sign-magnitude form. It is the reverse direction of the sign-magnitude adder's complement path: it returns adder results to sign-magnitude for display and for the next operand stage. It processes one magnitude bit per clock, LSB first, using the copy-to-first-one-then-invert rule. Input and output each use a valid/ready handshake.

Parameters:
W, 8, total word width (1 sign bit + W-1 magnitude bits); legal range W >= 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  in_data is valid
in_ready  output  1  converter can accept a word; equals (state==IDLE)
in_data  input  W  two's-complement operand
out_valid  output  1  out_data/out_ovf valid; equals (state==DONE)
out_ready  input  1  consumer accepts the result
out_data  output  W  {sign, magnitude[W-2:0]}
out_ovf  output  1  input was the most negative value (2^(W-1) magnitude, not representable)
busy  output  1  state != IDLE

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, any state, including mid-conversion):
  - state=IDLE, bit counter=0, shift register=0, seen_one=0.
  - out_data=0, out_ovf=0.
  - Any conversion in flight is discarded and no result is produced.
  - After release, in_ready=1, out_valid=0, busy=0.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at edge E0:
    - latch sign=in_data[W-1] and shift register sr=in_data[W-2:0];
    - counter=0, seen_one=0;
    - go to CONVERT.
- CONVERT:
  - in_ready=0. in_data and in_valid are ignored.
  - Each edge consumes b=sr[0] and shifts the result bit r into the MSB end of the magnitude register. The LSB is processed first, so after W-1 shifts bit i sits at position i.
  - sign=0: r=b.
  - sign=1, seen_one=0: r=b; seen_one is set if b=1.
  - sign=1, seen_one=1: r=~b.
  - The counter increments every edge. On the edge that processes bit W-2 (counter==W-2):
    - load out_data={sign, mag};
    - load out_ovf = sign && (seen_one==0 after the final bit);
    - go to DONE.
- Latency: out_valid rises after edge E0+(W-1), i.e. 7 edges after acceptance for W=8.
- DONE:
  - out_valid=1. out_data and out_ovf are held stable until handshake.
  - On out_valid && out_ready: go to IDLE. The next word can be accepted one edge later.
  - out_ready low: stall indefinitely with no change.
- Throughput: one word per W+1 cycles minimum (out_ready held high, in_valid held high).
- No overlap: a new input is never accepted in DONE, even if out_ready is high in the same cycle.
- out_data/out_ovf keep the last result through IDLE and CONVERT until overwritten on the next entry to DONE.
- Most negative input {1,0...0}:
  - all magnitude bits are copied as 0;
  - result is out_data={1,0...0} (negative zero) with out_ovf=1.
- Zero input: out_data=0, out_ovf=0. Negative zero is never produced except in the overflow case.
- Positive inputs pass through unchanged (magnitude = in_data[W-2:0]).
- No arithmetic carry chain is used; the only state is sr, mag, counter (ceil(log2(W)) bits), seen_one, sign and FSM.

Test Plan:
- Reset then positive input (W=8): in_data=8'h05 accepted at E0 -> out_valid rises after E7, out_data=8'h05, out_ovf=0; busy high E0..handshake.
- Negative values: 8'hFF -> 8'h81; 8'hFB -> 8'h85; 8'h81 -> 8'hFF. In every case out_ovf=0.
- Boundaries:
  - 8'h00 -> 8'h00, ovf=0;
  - 8'h7F -> 8'h7F, ovf=0;
  - 8'h80 -> 8'h80, ovf=1.
  - W=2: 2'b11 -> 2'b11; 2'b10 -> 2'b10 with ovf=1.
- Backpressure and stability:
  - hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data/out_ovf stable, in_ready=0;
  - toggle in_data/in_valid during CONVERT -> result unaffected.
- Back-to-back with in_valid and out_ready tied high, inputs 8'hFE, 8'h03 -> results 8'h82 then 8'h03. The second acceptance occurs exactly W+1=9 edges after the first.
- Async reset asserted mid-CONVERT (after 3 bits of 8'hF0) -> immediate IDLE, out_valid=0, out_data=0. A following 8'hF0 conversion yields 8'h90 with no residue from the aborted word.

Source files
------------

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first.
// Negative words use copy-up-to-first-one-then-invert; no carry chain.
module twos_to_signmag_serial #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         busy
);

  localparam int unsigned MagW = W - 1;
  localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [MagW-1:0]   sr_q, sr_d;
  logic [MagW-1:0]   mag_q, mag_d;
  logic              seen_q, seen_d;
  logic              sign_q, sign_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              out_ovf_q, out_ovf_d;

  logic              cur_bit;
  logic              res_bit;
  logic              seen_nxt;
  logic [MagW-1:0]   mag_nxt;

  // Result bit for the current magnitude position; shared by both branches below.
  always_comb begin
    cur_bit  = sr_q[0];
    res_bit  = (sign_q && seen_q) ? ~cur_bit : cur_bit;
    seen_nxt = seen_q | (sign_q & cur_bit);
    mag_nxt  = mag_q >> 1;
    mag_nxt[MagW-1] = res_bit;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    mag_d      = mag_q;
    seen_d     = seen_q;
    sign_d     = sign_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = in_data[W-1];
          sr_d    = in_data[W-2:0];
          mag_d   = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
          state_d = StConvert;
        end
      end

      StConvert: begin
        sr_d   = sr_q >> 1;
        mag_d  = mag_nxt;
        seen_d = seen_nxt;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(W - 2)) begin
          out_data_d = {sign_q, mag_nxt};
          // No one among the magnitude bits of a negative word: most negative value.
          out_ovf_d  = sign_q & ~seen_nxt;
          state_d    = StDone;
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sr_q       <= '0;
      mag_q      <= '0;
      seen_q     <= 1'b0;
      sign_q     <= 1'b0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      mag_q      <= mag_d;
      seen_q     <= seen_d;
      sign_q     <= sign_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for the serial converter: W=8 instance plus a W=2 instance.
module tb_twos_to_signmag_serial;

  logic       clk;
  logic       rst_n;

  logic       in_valid, in_ready, out_valid, out_ready, out_ovf, busy;
  logic [7:0] in_data, out_data;

  logic       w2_in_valid, w2_in_ready, w2_out_valid, w2_out_ready, w2_out_ovf, w2_busy;
  logic [1:0] w2_in_data, w2_out_data;

  int n_checks;
  int n_fail;

  twos_to_signmag_serial #(.W(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf),
    .busy     (busy)
  );

  twos_to_signmag_serial #(.W(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (w2_in_valid),
    .in_ready (w2_in_ready),
    .in_data  (w2_in_data),
    .out_valid(w2_out_valid),
    .out_ready(w2_out_ready),
    .out_data (w2_out_data),
    .out_ovf  (w2_out_ovf),
    .busy     (w2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Convert one word on the W=8 instance; inputs are scrambled while converting.
  task automatic run8(input string tag, input logic [7:0] d, input logic [7:0] exp_d,
                      input logic exp_ovf, input int stall);
    int n;
    logic [7:0] held;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq({tag, "_lat"}, 32'(n), 32'd7);
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp_d));
    check_eq({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_stall_data"}, 32'(out_data), 32'(exp_d));
      check_eq({tag, "_stall_ovf"}, 32'(out_ovf), 32'(exp_ovf));
      check_eq({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_keep_data"}, 32'(out_data), 32'(held));
  endtask

  task automatic run2(input string tag, input logic [1:0] d, input logic [1:0] exp_d,
                      input logic exp_ovf);
    int n;
    @(negedge clk);
    w2_in_valid = 1'b1;
    w2_in_data  = d;
    @(posedge clk);
    @(negedge clk);
    w2_in_valid = 1'b0;
    n = 0;
    while (!w2_out_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check_eq({tag, "_lat"}, 32'(n), 32'd1);
    check_eq({tag, "_data"}, 32'(w2_out_data), 32'(exp_d));
    check_eq({tag, "_ovf"}, 32'(w2_out_ovf), 32'(exp_ovf));
    w2_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    w2_out_ready = 1'b0;
  endtask

  initial begin
    int t, nacc, nres;
    int acc_t [2];
    logic [7:0] res [2];

    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    w2_in_valid  = 1'b0;
    w2_in_data   = '0;
    w2_out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);

    run8("pos05", 8'h05, 8'h05, 1'b0, 0);
    run8("negFF", 8'hFF, 8'h81, 1'b0, 0);
    run8("negFB", 8'hFB, 8'h85, 1'b0, 0);
    run8("neg81", 8'h81, 8'hFF, 1'b0, 0);
    run8("zero", 8'h00, 8'h00, 1'b0, 0);
    run8("max7F", 8'h7F, 8'h7F, 1'b0, 0);
    run8("min80", 8'h80, 8'h80, 1'b1, 0);
    run8("stallC4", 8'hC4, 8'hBC, 1'b0, 10);

    run2("w2_11", 2'b11, 2'b11, 1'b0);
    run2("w2_10", 2'b10, 2'b10, 1'b1);
    run2("w2_01", 2'b01, 2'b01, 1'b0);

    // Back-to-back with both handshakes held high.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'hFE;
    out_ready = 1'b1;
    nacc = 0;
    nres = 0;
    t    = 0;
    while (nres < 2 && t < 60) begin
      if (in_ready && in_valid && nacc < 2) begin
        acc_t[nacc] = t;
        nacc++;
      end
      if (out_valid) begin
        res[nres] = out_data;
        nres++;
      end
      @(posedge clk);
      t++;
      @(negedge clk);
      if (nacc == 1) in_data = 8'h03;
      if (nacc == 2) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("b2b_nres", 32'(nres), 32'd2);
    check_eq("b2b_nacc", 32'(nacc), 32'd2);
    if (nres == 2 && nacc == 2) begin
      check_eq("b2b_res0", 32'(res[0]), 32'h82);
      check_eq("b2b_res1", 32'(res[1]), 32'h03);
      check_eq("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd9);
    end

    // Abort mid-conversion after three bits have been shifted.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hF0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_in_ready", 32'(in_ready), 32'd1);
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_out_data", 32'(out_data), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8("afterF0", 8'hF0, 8'h90, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
